uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each one-cycle byte-valid strobe and byte from the receiver into a circular FIFO.
- Exposes a registered pop interface, occupancy, and a sticky overrun flag to the MCU peripheral bus.
- Raises a level-threshold interrupt so the CPU does not have to service every byte.

Parameters:
- DATA_W, 8, width of each stored byte.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W.
- DEPTH, 16, entry count; must equal 2**ADDR_W.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of i_Clock.
- i_Rx_DV  in  1  one-cycle strobe from receiver: byte valid.
- i_Rx_Byte  in  DATA_W  received byte, qualified by i_Rx_DV.
- rd_en  in  1  pop request from bus.
- flush  in  1  discard all stored entries.
- clr_ovr  in  1  clear sticky overrun flag.
- THRESH  in  ADDR_W+1  interrupt threshold value.
- ld_THRESH  in  1  load THRESH into internal threshold register.
- o_Rd_Data  out  DATA_W  popped byte, registered.
- o_Rd_Valid  out  1  one-cycle strobe: o_Rd_Data holds a newly popped byte.
- o_Empty  out  1  level == 0.
- o_Full  out  1  level == DEPTH.
- o_Level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- o_Irq  out  1  level >= threshold and threshold != 0.

Behaviour:
- Reset (rst==0 at a clock edge):
  - wr_ptr, rd_ptr, level, o_Rd_Data, o_Rd_Valid, o_Overrun all go to 0.
  - Threshold register goes to 0; o_Empty=1, o_Full=0, o_Irq=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all content immediately.
- Internal state is wr_ptr[ADDR_W-1:0], rd_ptr[ADDR_W-1:0], and level[ADDR_W:0]. Pointers wrap modulo DEPTH naturally.
- Push (i_Rx_DV==1):
  - Accepted if level < DEPTH, or if a pop is accepted in the same cycle.
  - Accept writes mem[wr_ptr] and increments wr_ptr.
  - Not accepted: byte dropped, o_Overrun <= 1 next cycle, pointers unchanged.
- Pop (rd_en==1):
  - Accepted only if level > 0 at cycle start.
  - Accept: o_Rd_Data <= mem[rd_ptr], rd_ptr increments, o_Rd_Valid <= 1 for one cycle.
  - Read latency is 1 cycle.
  - Pop on empty: ignored, o_Rd_Valid=0, o_Rd_Data holds its last value.
  - No write-to-read bypass: a simultaneous push into an empty FIFO is stored, and the pop is ignored.
- o_Rd_Data holds its value when no pop is accepted.
- Level update: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
- Full with push and pop in the same cycle: both accepted, level stays DEPTH, no overrun.
- Flush (highest priority after reset):
  - Next cycle: wr_ptr=rd_ptr=0, level=0, o_Rd_Valid=0.
  - Any push or pop in the same cycle is discarded; a push discarded by flush does not set overrun.
  - o_Overrun and threshold are unaffected.
- clr_ovr: o_Overrun <= 0.
  - If a drop occurs in the same cycle, set wins and o_Overrun=1.
- ld_THRESH: threshold <= THRESH next cycle; otherwise it holds. Values > DEPTH are stored as given, so o_Irq never asserts.
- Combinational outputs from registers: o_Empty, o_Full, o_Level, o_Irq. No comb path from inputs to outputs.

Test Plan:
- Reset, then 16 bytes 0x00..0x0F pushed on i_Rx_DV strobes (one per 10 cycles) -> o_Level=16, o_Full=1, o_Overrun=0; 16 pops -> o_Rd_Valid pulses with data 0x00..0x0F in order, o_Empty=1 after the last.
- Full FIFO, push 0xAA -> byte dropped, o_Overrun=1, level 16; pops return original data with no 0xAA; clr_ovr -> o_Overrun=0.
- Full FIFO, push 0x55 and pop in the same cycle -> o_Rd_Data=oldest byte, level stays 16, o_Overrun=0; 0x55 emerges as the 16th pop afterward.
- Empty FIFO, push 0x3C with rd_en in the same cycle -> o_Rd_Valid=0, level=1; next pop returns 0x3C. Pop on empty -> o_Rd_Valid=0, o_Rd_Data unchanged.
- ld_THRESH with THRESH=4, then push 4 bytes -> o_Irq rises in the cycle level reaches 4 and falls after one pop; THRESH=0 -> o_Irq stays 0.
- 20 push/pop cycles for pointer wrap, then flush asserted together with i_Rx_DV -> level=0, o_Empty=1, overrun unchanged. Separately, rst low mid-stream -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle between the UART receive FIFO and its users.
// slave = the FIFO itself, master = receiver/peripheral-bus side.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              i_Rx_DV;
  logic [DATA_W-1:0] i_Rx_Byte;
  logic              rd_en;
  logic              flush;
  logic              clr_ovr;
  logic [ADDR_W:0]   THRESH;
  logic              ld_THRESH;
  logic [DATA_W-1:0] o_Rd_Data;
  logic              o_Rd_Valid;
  logic              o_Empty;
  logic              o_Full;
  logic [ADDR_W:0]   o_Level;
  logic              o_Overrun;
  logic              o_Irq;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, rd_en, flush, clr_ovr, THRESH, ld_THRESH,
    output o_Rd_Data, o_Rd_Valid, o_Empty, o_Full, o_Level, o_Overrun, o_Irq
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, rd_en, flush, clr_ovr, THRESH, ld_THRESH,
    input  o_Rd_Data, o_Rd_Valid, o_Empty, o_Full, o_Level, o_Overrun, o_Irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive circular FIFO; pop data registered, 1-cycle read latency.
// No backpressure to the receiver: bytes arriving while full are dropped and flagged as overrun.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic          i_Clock,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   level_q,    level_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovr_q,      ovr_d;
  logic [ADDR_W:0]   thresh_q,   thresh_d;

  logic pop_acc;
  logic push_acc;
  logic drop;

  always_comb begin
    // Flush discards both sides of the cycle, so neither counts as accepted or dropped.
    pop_acc  = bus.rd_en && (level_q != '0) && !bus.flush;
    push_acc = bus.i_Rx_DV && !bus.flush && ((level_q != FULL_LVL) || pop_acc);
    drop     = bus.i_Rx_DV && !bus.flush && !push_acc;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = pop_acc;
    ovr_d      = ovr_q;
    thresh_d   = thresh_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_acc) begin
        rd_data_d = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      end
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (push_acc && !pop_acc) begin
        level_d = level_q + (ADDR_W+1)'(1);
      end else if (pop_acc && !push_acc) begin
        level_d = level_q - (ADDR_W+1)'(1);
      end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    if (bus.clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end

    if (bus.ld_THRESH) begin
      thresh_d = bus.THRESH;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      thresh_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovr_q      <= ovr_d;
      thresh_q   <= thresh_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_Clock) begin
    if (rst && push_acc) begin
      mem_q[wr_ptr_q] <= bus.i_Rx_Byte;
    end
  end

  assign bus.o_Rd_Data  = rd_data_q;
  assign bus.o_Rd_Valid = rd_valid_q;
  assign bus.o_Empty    = (level_q == '0);
  assign bus.o_Full     = (level_q == FULL_LVL);
  assign bus.o_Level    = level_q;
  assign bus.o_Overrun  = ovr_q;
  assign bus.o_Irq      = (thresh_q != '0) && (level_q >= thresh_q);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_Clock (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents are just a queue.
  logic [7:0] mq[$];
  logic [7:0] m_rd_data;
  bit         m_rd_valid;
  bit         m_ovr;
  int         m_thr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = '0;
    bus.rd_en     = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_ovr   = 1'b0;
    bus.ld_THRESH = 1'b0;
    bus.THRESH    = '0;
  endtask

  task automatic model_step();
    bit pop_ok, push_ok;
    if (!rst) begin
      mq.delete();
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_ovr      = 1'b0;
      m_thr      = 0;
    end else begin
      m_rd_valid = 1'b0;
      if (bus.flush) begin
        mq.delete();
      end else begin
        pop_ok  = bus.rd_en && (mq.size() > 0);
        push_ok = bus.i_Rx_DV && ((mq.size() < DEPTH) || pop_ok);
        if (pop_ok) begin
          m_rd_data  = mq.pop_front();
          m_rd_valid = 1'b1;
        end
        if (push_ok) mq.push_back(bus.i_Rx_Byte);
        if (bus.clr_ovr) m_ovr = 1'b0;
        if (bus.i_Rx_DV && !push_ok) m_ovr = 1'b1;
      end
      if (bus.flush && bus.clr_ovr) m_ovr = 1'b0;
      if (bus.ld_THRESH) m_thr = int'(bus.THRESH);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare every output.
  task automatic tick();
    int lvl;
    model_step();
    @(posedge clk);
    #1;
    lvl = mq.size();
    chk("level",    32'(bus.o_Level),    32'(lvl));
    chk("empty",    32'(bus.o_Empty),    32'(lvl == 0));
    chk("full",     32'(bus.o_Full),     32'(lvl == DEPTH));
    chk("rd_valid", 32'(bus.o_Rd_Valid), 32'(m_rd_valid));
    chk("rd_data",  32'(bus.o_Rd_Data),  32'(m_rd_data));
    chk("overrun",  32'(bus.o_Overrun),  32'(m_ovr));
    chk("irq",      32'(bus.o_Irq),      32'((m_thr != 0) && (lvl >= m_thr)));
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    tick();
    idle();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_thresh(input logic [ADDR_W:0] t);
    bus.ld_THRESH = 1'b1;
    bus.THRESH    = t;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_empty", 32'(bus.o_Empty), 32'd1);
    chk("rst_level", 32'(bus.o_Level), 32'd0);
    rst = 1'b1;
    tick();

    // Slow fill with 0x00..0x0F, then an extra byte that must be dropped.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      repeat (9) tick();
    end
    chk("fill_level", 32'(bus.o_Level), 32'd16);
    chk("fill_full",  32'(bus.o_Full), 32'd1);
    chk("fill_ovr",   32'(bus.o_Overrun), 32'd0);
    push(8'hAA);
    chk("drop_ovr",   32'(bus.o_Overrun), 32'd1);
    chk("drop_level", 32'(bus.o_Level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("order_data",  32'(bus.o_Rd_Data), 32'(i));
      chk("order_valid", 32'(bus.o_Rd_Valid), 32'd1);
    end
    chk("drain_empty", 32'(bus.o_Empty), 32'd1);
    bus.clr_ovr = 1'b1;
    tick();
    idle();
    chk("clr_ovr", 32'(bus.o_Overrun), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'h55;
    bus.rd_en     = 1'b1;
    tick();
    idle();
    chk("fullpp_data",  32'(bus.o_Rd_Data), 32'h10);
    chk("fullpp_level", 32'(bus.o_Level), 32'd16);
    chk("fullpp_ovr",   32'(bus.o_Overrun), 32'd0);
    for (int i = 0; i < 16; i++) pop();
    chk("fullpp_last", 32'(bus.o_Rd_Data), 32'h55);

    // Empty with simultaneous push and pop: no bypass.
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'h3C;
    bus.rd_en     = 1'b1;
    tick();
    idle();
    chk("emptypp_valid", 32'(bus.o_Rd_Valid), 32'd0);
    chk("emptypp_level", 32'(bus.o_Level), 32'd1);
    pop();
    chk("emptypp_data", 32'(bus.o_Rd_Data), 32'h3C);
    pop();
    chk("popempty_valid", 32'(bus.o_Rd_Valid), 32'd0);
    chk("popempty_data",  32'(bus.o_Rd_Data), 32'h3C);

    // Threshold interrupt.
    load_thresh(5'd4);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'hC0 + i));
      chk("irq_rise", 32'(bus.o_Irq), 32'(i == 3));
    end
    pop();
    chk("irq_fall", 32'(bus.o_Irq), 32'd0);
    load_thresh(5'd0);
    for (int i = 0; i < 4; i++) push(8'(8'hD0 + i));
    chk("irq_zero", 32'(bus.o_Irq), 32'd0);
    while (mq.size() > 0) pop();

    // Set overrun, wrap pointers while full, then flush alongside a push.
    for (int i = 0; i < 17; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = 8'(8'h40 + i);
      bus.rd_en     = 1'b1;
      tick();
    end
    idle();
    bus.flush     = 1'b1;
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'hEE;
    tick();
    idle();
    chk("flush_level", 32'(bus.o_Level), 32'd0);
    chk("flush_empty", 32'(bus.o_Empty), 32'd1);
    chk("flush_ovr",   32'(bus.o_Overrun), 32'd1);
    push(8'h71);
    push(8'h72);
    pop();
    chk("post_flush_data", 32'(bus.o_Rd_Data), 32'h71);

    // Reset mid-stream.
    load_thresh(5'd1);
    push(8'h73);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'h74;
    bus.rd_en     = 1'b1;
    rst = 1'b0;
    tick();
    idle();
    chk("midrst_level", 32'(bus.o_Level), 32'd0);
    chk("midrst_ovr",   32'(bus.o_Overrun), 32'd0);
    chk("midrst_data",  32'(bus.o_Rd_Data), 32'd0);
    chk("midrst_valid", 32'(bus.o_Rd_Valid), 32'd0);
    chk("midrst_irq",   32'(bus.o_Irq), 32'd0);
    rst = 1'b1;
    tick();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 299) != 0);
      bus.i_Rx_DV   = ($urandom_range(0, 99) < 55);
      bus.i_Rx_Byte = 8'($urandom);
      bus.rd_en     = ($urandom_range(0, 99) < 45);
      bus.flush     = ($urandom_range(0, 79) == 0);
      bus.clr_ovr   = ($urandom_range(0, 29) == 0);
      bus.ld_THRESH = ($urandom_range(0, 39) == 0);
      bus.THRESH    = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
